branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_unit.sv | 114 +++++++++++
 tb/tb_branch_cond_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Branch condition unit: captures an operand and a condition code on request,
// evaluates the condition one cycle later and holds the registered decision
// until the control unit acknowledges it. Dropped requests raise a sticky
// overrun flag; taken decisions are counted with saturation.
//
// Handshake: a request is con_in=1 sampled on a rising edge while the unit
// can accept it (IDLE, or DONE together with ack=1). The result is offered
// with valid=1 and held stable until ack=1 is sampled in DONE. A request seen
// while busy and not simultaneously retiring the current result is dropped.
module branch_cond_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             con_in,
  input  logic [2:0]       ir_cc,
  input  logic [WIDTH-1:0] bus,
  input  logic             ack,
  output logic             con_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // state_q is the FSM state register; it is the signal to probe for state.
  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] cap_bus;
  logic [2:0]       cap_cc;
  logic             capture;
  logic             drop;
  logic             cond_hit;
  logic             op_zero;
  logic             op_neg;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // State register, cleared asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: EVAL always lasts one cycle; DONE retires on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (con_in) state_d = EVAL;
      EVAL:    state_d = DONE;
      DONE:    if (ack) state_d = con_in ? EVAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode plus request accept/drop qualification from the state.
  always_comb begin
    busy    = (state_q == EVAL) || (state_q == DONE);
    capture = con_in && ((state_q == IDLE) || ((state_q == DONE) && ack));
    drop    = con_in && ((state_q == EVAL) || ((state_q == DONE) && !ack));
  end

  // Condition evaluation on the captured operand only, never the live bus.
  always_comb begin
    op_zero  = (cap_bus == '0);
    op_neg   = cap_bus[WIDTH-1];
    cond_hit = 1'b0;
    case (cap_cc)
      3'b000:  cond_hit = op_zero;
      3'b001:  cond_hit = !op_zero;
      3'b010:  cond_hit = !op_neg;
      3'b011:  cond_hit = op_neg;
      3'b100:  cond_hit = !op_neg && !op_zero;
      3'b101:  cond_hit = op_neg || op_zero;
      3'b110:  cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  end

  // Capture registers, result register, valid, sticky overrun and counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cap_bus   <= '0;
      cap_cc    <= '0;
      con_out   <= 1'b0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      taken_cnt <= '0;
    end else begin
      if (capture) begin
        cap_bus <= bus;
        cap_cc  <= ir_cc;
      end
      if (state_q == EVAL) begin
        con_out <= cond_hit;
        valid   <= 1'b1;
        if (cond_hit && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_ONE;
      end else if ((state_q == DONE) && ack) begin
        valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed scenarios plus randomized requests
// checked against a signed-arithmetic reference of the condition codes.
module tb_branch_cond_unit;

  localparam int W = 32;

  logic         clk;
  logic         clr;
  logic         con_in;
  logic [2:0]   ir_cc;
  logic [W-1:0] bus;
  logic         ack;
  logic         con_out, valid, busy, overrun;
  logic [7:0]   taken_cnt;
  logic         con_out2, valid2, busy2, overrun2;
  logic [1:0]   taken_cnt2;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_cond_unit #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .con_in(con_in), .ir_cc(ir_cc), .bus(bus), .ack(ack),
    .con_out(con_out), .valid(valid), .busy(busy), .overrun(overrun),
    .taken_cnt(taken_cnt)
  );

  branch_cond_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .clr(clr), .con_in(con_in), .ir_cc(ir_cc), .bus(bus), .ack(ack),
    .con_out(con_out2), .valid(valid2), .busy(busy2), .overrun(overrun2),
    .taken_cnt(taken_cnt2)
  );

  // ---------------- reference model ----------------
  function automatic logic ref_cond(input logic [2:0] cc, input logic [W-1:0] b);
    int signed s;
    s = int'(signed'(b));
    case (cc)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s >= 0;
      3'd3: return s < 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    con_in = 0; ack = 0;
    clr = 1;
    #3;
    clr = 0;
    tick();
    exp_cnt = 0;
  endtask

  // Presents a request and lets the edge sample it; returns with DUT in EVAL.
  task automatic start_req(input logic [2:0] cc, input logic [W-1:0] b);
    con_in = 1; ir_cc = cc; bus = b;
    tick();
    con_in = 0;
  endtask

  task automatic finish_ack();
    ack = 1;
    tick();
    ack = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1; con_in = 0; ack = 0; ir_cc = 0; bus = 0;
    #1;
    checks++; if (con_out !== 1'b0) begin errors++; $display("FAIL reset_con_out: got %b want 0", con_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (taken_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt); end
    #3; clr = 0;
    tick();
    // clr pulse between edges while in DONE
    start_req(3'd6, 32'd1);
    tick();
    checks++; if (valid !== 1'b1 || taken_cnt !== 8'd1) begin errors++; $display("FAIL pre_clr_done: valid=%b cnt=%0d want 1/1", valid, taken_cnt); end
    clr = 1;
    #2;
    checks++; if ({con_out, valid, busy, overrun} !== 4'b0000) begin errors++; $display("FAIL clr_in_done: out/valid/busy/ovr=%b want 0000", {con_out, valid, busy, overrun}); end
    checks++; if (taken_cnt !== 8'd0) begin errors++; $display("FAIL clr_in_done_cnt: got %0d want 0", taken_cnt); end
    clr = 0;
    tick();
    // clr during EVAL aborts without result or count
    start_req(3'd6, 32'd2);
    clr = 1; #2; clr = 0;
    tick();
    checks++; if ({valid, busy, con_out} !== 3'b000 || taken_cnt !== 8'd0) begin errors++; $display("FAIL clr_in_eval: valid/busy/out=%b cnt=%0d want 000/0", {valid, busy, con_out}, taken_cnt); end
    // request presented while clr is high is accepted on the first edge after release
    clr = 1; con_in = 1; ir_cc = 3'd6; bus = 0;
    #2; clr = 0;
    tick();
    con_in = 0;
    checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL post_clr_accept: busy=%b valid=%b want 1/0", busy, valid); end
    tick();
    checks++; if (valid !== 1'b1 || con_out !== 1'b1) begin errors++; $display("FAIL post_clr_result: valid=%b out=%b want 1/1", valid, con_out); end
    finish_ack();
    do_reset();
  endtask

  task automatic test_all_codes();
    logic [2:0]   tbl [8];
    logic [W-1:0] vals [3];
    logic         want;
    tbl  = '{3'b100, 3'b011, 3'b110, 3'b001, 3'b010, 3'b101, 3'b111, 3'b000};
    vals = '{32'h00000000, 32'h00000005, 32'hFFFFFFFB};
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 3; j++) begin
        want = tbl[c][2-j];
        start_req(3'(c), vals[j]);
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL code%0d_v%0d_edge1: valid=%b busy=%b want 0/1", c, j, valid, busy); end
        tick();
        checks++; if (valid !== 1'b1 || con_out !== want) begin errors++; $display("FAIL code%0d_v%0d: valid=%b out=%b want 1/%b", c, j, valid, con_out, want); end
        if (want) exp_cnt++;
        checks++; if (taken_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL code%0d_v%0d_cnt: got %0d want %0d", c, j, taken_cnt, exp_cnt); end
        finish_ack();
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]   cc;
    logic [W-1:0] b;
    logic         want;
    int           hold;
    for (int n = 0; n < 40; n++) begin
      cc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'h80000000;
        2: b = 32'h1;
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      want = ref_cond(cc, b);
      ack = ($urandom_range(0, 1) == 1);  // ack while idle must be ignored
      start_req(cc, b);
      ack = 0;
      bus = $urandom;                     // later bus changes must not matter
      tick();
      if (want) exp_cnt++;
      checks++; if (valid !== 1'b1 || con_out !== want) begin errors++; $display("FAIL rand%0d cc=%0d bus=%h: valid=%b out=%b want 1/%b", n, cc, b, valid, con_out, want); end
      checks++; if (taken_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rand%0d_cnt: got %0d want %0d", n, taken_cnt, exp_cnt); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        bus = $urandom;
        tick();
        checks++; if (valid !== 1'b1 || con_out !== want) begin errors++; $display("FAIL rand%0d_hold%0d: valid=%b out=%b want 1/%b", n, h, valid, con_out, want); end
      end
      finish_ack();
      checks++; if (valid !== 1'b0 || busy !== 1'b0 || con_out !== want) begin errors++; $display("FAIL rand%0d_ack: valid=%b busy=%b out=%b want 0/0/%b", n, valid, busy, con_out, want); end
    end
  endtask

  task automatic test_capture();
    start_req(3'd0, 32'd0);
    bus = 32'd7;
    tick();
    exp_cnt++;
    checks++; if (con_out !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL capture: out=%b valid=%b want 1/1", con_out, valid); end
    finish_ack();
  endtask

  task automatic test_overrun();
    do_reset();
    start_req(3'd6, 32'd0);
    con_in = 1; ir_cc = 3'd7; bus = 32'd5;   // second request during EVAL
    tick();
    con_in = 0;
    checks++; if (valid !== 1'b1 || con_out !== 1'b1) begin errors++; $display("FAIL ovr_result: valid=%b out=%b want 1/1", valid, con_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (taken_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt: got %0d want 1", taken_cnt); end
    finish_ack();
    tick();
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_after_ack: busy=%b valid=%b ovr=%b want 0/0/1", busy, valid, overrun); end
    // drop in DONE without ack
    start_req(3'd7, 32'd0);
    tick();
    con_in = 1; ir_cc = 3'd6;
    tick();
    con_in = 0;
    checks++; if (valid !== 1'b1 || con_out !== 1'b0 || taken_cnt !== 8'd1) begin errors++; $display("FAIL ovr_done_drop: valid=%b out=%b cnt=%0d want 1/0/1", valid, con_out, taken_cnt); end
    finish_ack();
    checks++; if (busy !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_done_idle: busy=%b ovr=%b want 0/1", busy, overrun); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    start_req(3'd6, 32'd1);
    tick();
    exp_cnt++;
    ack = 1; con_in = 1; ir_cc = 3'd7; bus = 32'd0;
    tick();
    ack = 0; con_in = 0;
    checks++; if (valid !== 1'b0 || busy !== 1'b1 || con_out !== 1'b1) begin errors++; $display("FAIL b2b_gap: valid=%b busy=%b out=%b want 0/1/1", valid, busy, con_out); end
    tick();
    checks++; if (valid !== 1'b1 || con_out !== 1'b0) begin errors++; $display("FAIL b2b_second: valid=%b out=%b want 1/0", valid, con_out); end
    checks++; if (taken_cnt !== 8'(exp_cnt) || overrun !== 1'b0) begin errors++; $display("FAIL b2b_cnt: cnt=%0d ovr=%b want %0d/0", taken_cnt, overrun, exp_cnt); end
    finish_ack();
  endtask

  task automatic test_saturation();
    int want_sat;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      start_req(3'd6, $urandom);
      tick();
      want_sat = (i > 3) ? 3 : i;
      checks++; if (taken_cnt2 !== 2'(want_sat)) begin errors++; $display("FAIL sat%0d: got %0d want %0d", i, taken_cnt2, want_sat); end
      checks++; if (taken_cnt !== 8'(i)) begin errors++; $display("FAIL sat%0d_wide: got %0d want %0d", i, taken_cnt, i); end
      finish_ack();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_all_codes();
    test_capture();
    test_random();
    test_back_to_back();
    test_overrun();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
